// File: rtl/frogger_pkg.sv
// Shared Frogger display constants: color codes understood by color_mapper,
// active-video geometry and the background lane palette.
package frogger_pkg;

   localparam logic [5:0] CC_TRANSPARENT = 6'd0;
   localparam logic [5:0] CC_BLACK       = 6'd1;
   localparam logic [5:0] CC_GREEN       = 6'd2;
   localparam logic [5:0] CC_RED         = 6'd3;
   localparam logic [5:0] CC_LIGHT_BLUE  = 6'd4;
   localparam logic [5:0] CC_BLUE        = 6'd5;
   localparam logic [5:0] CC_GREY        = 6'd6;
   localparam logic [5:0] CC_YELLOW      = 6'd7;
   localparam logic [5:0] CC_ORANGE      = 6'd8;
   localparam logic [5:0] CC_BROWN       = 6'd9;
   localparam logic [5:0] CC_PURPLE      = 6'd10;
   localparam logic [5:0] CC_WHITE       = 6'd11;

   localparam int unsigned H_ACTIVE = 640;
   localparam int unsigned V_ACTIVE = 480;

   // Lanes are 32 rows tall: grass, river, median, road, grass.
   function automatic logic [5:0] lane_color(input logic [4:0] lane);
      logic [5:0] cc;
      if (lane <= 5'd1) begin
         cc = CC_GREEN;
      end else if (lane <= 5'd6) begin
         cc = CC_LIGHT_BLUE;
      end else if (lane == 5'd7) begin
         cc = CC_GREY;
      end else if (lane <= 5'd12) begin
         cc = CC_BLACK;
      end else begin
         cc = CC_GREEN;
      end
      return cc;
   endfunction

endpackage

// File: rtl/obj_hit_test.sv
// Single rectangle hit test; the horizontal extent wraps around the
// right screen edge back to column 0.
module obj_hit_test
   import frogger_pkg::*;
#(
   parameter int unsigned OBJ_W = 64,
   parameter int unsigned OBJ_H = 32
) (
   input  logic [9:0] draw_x,
   input  logic [9:0] draw_y,
   input  logic [9:0] obj_x,
   input  logic [9:0] obj_y,
   output logic       hit
);

   logic [10:0] dx_raw;
   logic [10:0] dx_wrap;
   logic [10:0] dy;

   always_comb begin
      dx_raw  = {1'b0, draw_x} - {1'b0, obj_x};
      // A borrow means the pixel lies left of the object: fold it modulo the line width.
      dx_wrap = dx_raw[10] ? (dx_raw + 11'(H_ACTIVE)) : dx_raw;
      dy      = {1'b0, draw_y} - {1'b0, obj_y};
      hit     = (dx_wrap < 11'(OBJ_W)) && (dy < 11'(OBJ_H));
   end

endmodule

// File: rtl/frog_pixel_compositor.sv
// Two-stage per-pixel compositor: frog sprite over lane objects over the
// background lane color, with object positions shadowed once per frame.
module frog_pixel_compositor
   import frogger_pkg::*;
#(
   parameter int unsigned NUM_OBJ = 4,
   parameter int unsigned OBJ_W   = 64,
   parameter int unsigned OBJ_H   = 32,
   parameter int unsigned FROG_SZ = 32
) (
   input  logic                      Clk,
   input  logic                      Reset_n,
   input  logic [9:0]                DrawX,
   input  logic [9:0]                DrawY,
   input  logic                      pix_valid,
   input  logic                      frame_start,
   input  logic [9:0]                frog_x,
   input  logic [9:0]                frog_y,
   input  logic                      frog_vis,
   input  logic [NUM_OBJ-1:0][9:0]   obj_x,
   input  logic [NUM_OBJ-1:0][9:0]   obj_y,
   input  logic [NUM_OBJ-1:0][5:0]   obj_color,
   output logic [9:0]                rom_addr,
   input  logic [5:0]                rom_data,
   output logic [5:0]                colorcode
);

   logic [9:0]                sh_frog_x, sh_frog_y;
   logic                      sh_frog_vis;
   logic [NUM_OBJ-1:0][9:0]   sh_obj_x, sh_obj_y;
   logic [NUM_OBJ-1:0][5:0]   sh_obj_color;

   logic [9:0]                cur_frog_x, cur_frog_y;
   logic                      cur_frog_vis;
   logic [NUM_OBJ-1:0][9:0]   cur_obj_x, cur_obj_y;
   logic [NUM_OBJ-1:0][5:0]   cur_obj_color;

   logic [10:0]               frog_dx, frog_dy;
   logic                      frog_hit;
   logic [9:0]                addr_d;
   logic [NUM_OBJ-1:0]        obj_hit;
   logic                      obj_any;
   logic [5:0]                obj_sel;
   logic [5:0]                bg_d;

   logic                      s1_valid, s1_frog_hit, s1_obj_draw;
   logic [5:0]                s1_obj_color, s1_bg;

   // The pixel sharing a cycle with frame_start already sees the new positions.
   always_comb begin
      cur_frog_x    = frame_start ? frog_x    : sh_frog_x;
      cur_frog_y    = frame_start ? frog_y    : sh_frog_y;
      cur_frog_vis  = frame_start ? frog_vis  : sh_frog_vis;
      cur_obj_x     = frame_start ? obj_x     : sh_obj_x;
      cur_obj_y     = frame_start ? obj_y     : sh_obj_y;
      cur_obj_color = frame_start ? obj_color : sh_obj_color;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         sh_frog_x    <= '0;
         sh_frog_y    <= '0;
         sh_frog_vis  <= 1'b0;
         sh_obj_x     <= '0;
         sh_obj_y     <= '0;
         sh_obj_color <= '0;
      end else if (frame_start) begin
         sh_frog_x    <= frog_x;
         sh_frog_y    <= frog_y;
         sh_frog_vis  <= frog_vis;
         sh_obj_x     <= obj_x;
         sh_obj_y     <= obj_y;
         sh_obj_color <= obj_color;
      end
   end

   always_comb begin
      frog_dx  = {1'b0, DrawX} - {1'b0, cur_frog_x};
      frog_dy  = {1'b0, DrawY} - {1'b0, cur_frog_y};
      frog_hit = cur_frog_vis && (frog_dx < 11'(FROG_SZ)) && (frog_dy < 11'(FROG_SZ));
      addr_d   = frog_hit ? {frog_dy[4:0], frog_dx[4:0]} : 10'd0;
      bg_d     = lane_color(DrawY[9:5]);
   end

   for (genvar i = 0; i < NUM_OBJ; i++) begin : g_obj
      obj_hit_test #(
         .OBJ_W (OBJ_W),
         .OBJ_H (OBJ_H)
      ) u_obj_hit_test (
         .draw_x (DrawX),
         .draw_y (DrawY),
         .obj_x  (cur_obj_x[i]),
         .obj_y  (cur_obj_y[i]),
         .hit    (obj_hit[i])
      );
   end

   always_comb begin
      obj_any = 1'b0;
      obj_sel = CC_TRANSPARENT;
      for (int i = 0; i < int'(NUM_OBJ); i++) begin
         if (obj_hit[i] && !obj_any) begin
            obj_any = 1'b1;
            obj_sel = cur_obj_color[i];
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         s1_valid     <= 1'b0;
         s1_frog_hit  <= 1'b0;
         s1_obj_draw  <= 1'b0;
         s1_obj_color <= CC_TRANSPARENT;
         s1_bg        <= CC_TRANSPARENT;
         rom_addr     <= '0;
         colorcode    <= CC_BLACK;
      end else begin
         s1_valid     <= pix_valid;
         s1_frog_hit  <= frog_hit;
         // A transparent winning object shows the background, not a lower-priority object.
         s1_obj_draw  <= obj_any && (obj_sel != CC_TRANSPARENT);
         s1_obj_color <= obj_sel;
         s1_bg        <= bg_d;
         rom_addr     <= addr_d;
         if (!s1_valid) begin
            colorcode <= CC_BLACK;
         end else if (s1_frog_hit && (rom_data != CC_TRANSPARENT)) begin
            colorcode <= rom_data;
         end else if (s1_obj_draw) begin
            colorcode <= s1_obj_color;
         end else begin
            colorcode <= s1_bg;
         end
      end
   end

endmodule

// File: doc/frog_pixel_compositor.md
# frog_pixel_compositor

Per-pixel scene compositor directly upstream of `color_mapper`. It takes the VGA scan position and game-object positions and produces the 6-bit `colorcode` consumed by the mapper, using that block's code set (0 transparent, 1 black, 2 green, 4 light blue, 6 grey, …, 11 white). Layers in priority order: frog sprite, lane objects (cars/logs), background lane color. It is a fixed 2-cycle pipeline, with object positions shadow-latched once per frame so the picture never tears.

## Interface
Parameters:
- `NUM_OBJ`, 4: number of rectangular lane objects
- `OBJ_W`, 64: object width in pixels
- `OBJ_H`, 32: object height in pixels
- `FROG_SZ`, 32: frog sprite edge length in pixels; must be 32 (5-bit row/col)

Ports (one clock; reset is asynchronous and active-low):
- `Clk` in 1: pixel clock
- `Reset_n` in 1: asynchronous, active-low reset
- `DrawX` in 10: current column, 0–639
- `DrawY` in 10: current row, 0–479
- `pix_valid` in 1: high in the active video region
- `frame_start` in 1: one-cycle pulse before the first active pixel of a frame
- `frog_x`, `frog_y` in 10 each: frog top-left corner
- `frog_vis` in 1: frog drawn when high
- `obj_x` in `NUM_OBJ`×10: object left edge, 0–639
- `obj_y` in `NUM_OBJ`×10: object top edge
- `obj_color` in `NUM_OBJ`×6: solid color code per object
- `rom_addr` out 10: frog ROM address {row[4:0], col[4:0]}
- `rom_data` in 6: frog ROM pixel, valid 1 cycle after `rom_addr`
- `colorcode` out 6: to `color_mapper`

## Operation
- Shadow registers hold `frog_x`, `frog_y`, `frog_vis`, `obj_x`, `obj_y`, `obj_color`. They load only on the cycle where `frame_start` is high; mid-frame changes to those inputs are ignored.
- **Stage 1** (registered) captures DrawX, DrawY and pix_valid, then computes:
  - Frog hit: `frog_vis` and (DrawX−frog_x) < 32 and (DrawY−frog_y) < 32, using 11-bit unsigned subtraction so negative differences fail.
  - `rom_addr` = {dy[4:0], dx[4:0]}; it is 0 when there is no frog hit.
  - Object hit i: (DrawY−obj_y[i]) < `OBJ_H`, and (DrawX−obj_x[i]) mod 640 < `OBJ_W`. The horizontal test wraps: an object at x=620 covers columns 620–639 and 0–43.
  - Object select: lowest-index hitting object wins.
  - Background: lane = DrawY[9:5], giving 0–14. Lanes 0–1 → 2 (green), 2–6 → 4 (light blue), 7 → 6 (grey), 8–12 → 1 (black), 13–14 → 2.
- **Stage 2** (registered into `colorcode`), first match wins:
  - pix_valid low → 1.
  - Frog hit and rom_data ≠ 0 → rom_data.
  - Any object hit → that object's obj_color. An obj_color of 0 is treated as transparent and falls through to background.
  - Otherwise → background code.
- No handshake. Every cycle produces one result, and there are no stalls.

## Timing
- Latency is 2 cycles: inputs in cycle n produce `colorcode` at the output after edge n+2.
- `rom_addr` is registered at edge n+1, and the ROM returns data at edge n+2, aligned with stage 2.
- Reset values: all pipeline and shadow registers are 0; `rom_addr` = 0; `colorcode` = 1 (black); stage-1 pix_valid = 0.
- Reset mid-frame: outputs go to reset values immediately. After release, objects are not drawn and the frog is not visible until the next `frame_start`.
- `frame_start` coinciding with an active pixel: that pixel already uses the new positions.
- Frog positions with x > 639 or y > 479 are legal; the frog is simply clipped.

## Structure
- Package `frogger_pkg` holds:
  - color-code localparams (`CC_TRANSPARENT`=0 … `CC_WHITE`=11), shared with `color_mapper`
  - `H_ACTIVE`=640 and `V_ACTIVE`=480
  - lane-to-color function
- One sub-module, `obj_hit_test`: a single-object wrap-aware rectangle test, instantiated `NUM_OBJ` times.

## Test plan
- Reset held, then released with pix_valid=0 → colorcode=1; rom_addr=0.
- No objects (obj_y=600), frog_vis=0, scan DrawY=100 and DrawY=260 → colorcode 4 and 1 respectively, 2 cycles after input.
- frog at (100,200), ROM returns 3 at addr {5'd4,5'd6} → at DrawX=106, DrawY=204, rom_addr=134 and colorcode=3. With rom_data=0 there → lane color 4 (lane 6).
- obj0 x=620, y=256, color 7; DrawY=260, DrawX=630, 10 and 44 → 7, 7, 1 (wrap check). obj1 overlapping with color 8 → obj0's color 7 wins.
- frog_x changes mid-frame with no frame_start → output unchanged. After a frame_start pulse → new position used.
